// File: rtl/uart_mem_loader_if.sv
// uart_mem_loader_if: UART byte stream and single-cycle memory port of the loader, grouped as one bundle.
interface uart_mem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        mem_valid;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        busy;
    modport master (
        input  rx_valid, rx_data, tx_ready, mem_rdata,
        output tx_valid, tx_data, mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr, busy
    );
    modport slave (
        output rx_valid, rx_data, tx_ready, mem_rdata,
        input  tx_valid, tx_data, mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr, busy
    );
endinterface

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: decodes SET_ADDR/WRITE/READ byte commands from the UART into byte accesses on the memory port.
module uart_mem_loader #(
    parameter logic [7:0] ACK_BYTE = 8'h06,
    parameter logic [7:0] NAK_BYTE = 8'h3F
) (
    input logic clk,
    input logic rst,
    uart_mem_loader_if.master bus
);
    typedef enum logic [3:0] {IDLE, ADDR, WLEN, WDATA, RLEN, RREQ, RWAIT, RSEND, RESP} state_t;
    state_t      state;
    logic [31:0] addr;
    logic [8:0]  count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            addr           <= '0;
            count          <= '0;
            bus.tx_valid   <= 1'b0;
            bus.tx_data    <= '0;
            bus.mem_valid  <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.mem_wmask  <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_addr   <= '0;
            bus.busy       <= 1'b0;
        end else begin
            bus.mem_valid <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_wmask <= '0;
            case (state)
                IDLE: if (bus.rx_valid) begin
                    bus.busy <= 1'b1;
                    count    <= '0;
                    case (bus.rx_data)
                        8'h01:   state <= ADDR;
                        8'h02:   state <= WLEN;
                        8'h03:   state <= RLEN;
                        default: begin
                            state        <= RESP;
                            bus.tx_valid <= 1'b1;
                            bus.tx_data  <= NAK_BYTE;
                        end
                    endcase
                end
                // little-endian: each new byte shifts in from the top
                ADDR: if (bus.rx_valid) begin
                    addr  <= {bus.rx_data, addr[31:8]};
                    count <= count + 9'd1;
                    if (count == 9'd3) begin
                        state        <= RESP;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= ACK_BYTE;
                    end
                end
                WLEN: if (bus.rx_valid) begin
                    count <= {~|bus.rx_data, bus.rx_data};
                    state <= WDATA;
                end
                WDATA: if (bus.rx_valid) begin
                    bus.mem_valid <= 1'b1;
                    bus.mem_write <= 1'b1;
                    bus.mem_wmask <= 4'b0001 << addr[1:0];
                    bus.mem_wdata <= {4{bus.rx_data}};
                    bus.mem_addr  <= {addr[31:2], 2'b00};
                    addr          <= addr + 32'd1;
                    count         <= count - 9'd1;
                    if (count == 9'd1) begin
                        state        <= RESP;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= ACK_BYTE;
                    end
                end
                // the read strobe is issued on entry so RREQ itself is the access cycle
                RLEN: if (bus.rx_valid) begin
                    count         <= {~|bus.rx_data, bus.rx_data};
                    bus.mem_valid <= 1'b1;
                    bus.mem_addr  <= {addr[31:2], 2'b00};
                    state         <= RREQ;
                end
                RREQ: state <= RWAIT;
                RWAIT: begin
                    bus.tx_data  <= bus.mem_rdata[{addr[1:0], 3'b000} +: 8];
                    bus.tx_valid <= 1'b1;
                    addr         <= addr + 32'd1;
                    count        <= count - 9'd1;
                    state        <= RSEND;
                end
                RSEND: if (bus.tx_ready) begin
                    bus.tx_valid <= 1'b0;
                    if (count != 9'd0) begin
                        bus.mem_valid <= 1'b1;
                        bus.mem_addr  <= {addr[31:2], 2'b00};
                        state         <= RREQ;
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RESP: if (bus.tx_ready) begin
                    bus.tx_valid <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: directed command streams; expected memory accesses and tx bytes are queued and a monitor compares them.
module tb_uart_mem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_mem_loader_if bif();
    uart_mem_loader dut (.clk(clk), .rst(rst), .bus(bif));

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } acc_t;

    acc_t        exp_mem[$];
    logic [7:0]  exp_tx[$];
    acc_t        mon_e;
    logic [7:0]  mon_b;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [logic [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) o[8*i +: 8] = d[8*i +: 8];
        return o;
    endfunction

    always @(posedge clk) begin
        if (bif.mem_valid && !bif.mem_write)
            bif.mem_rdata <= mem.exists(bif.mem_addr) ? mem[bif.mem_addr] : 32'h0;
        if (bif.mem_valid && bif.mem_write)
            mem[bif.mem_addr] = merge(mem.exists(bif.mem_addr) ? mem[bif.mem_addr] : 32'h0, bif.mem_wdata, bif.mem_wmask);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bif.mem_valid) begin
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected: got access at %h expected none", bif.mem_addr);
                end else begin
                    mon_e = exp_mem.pop_front();
                    check("mem_write", 32'(bif.mem_write), 32'(mon_e.wr));
                    check("mem_addr", bif.mem_addr, mon_e.addr);
                    check("mem_wmask", 32'(bif.mem_wmask), 32'(mon_e.mask));
                    if (mon_e.wr) check("mem_wdata", bif.mem_wdata, mon_e.data);
                end
            end
            if (bif.tx_valid && bif.tx_ready) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got byte %h expected none", bif.tx_data);
                end else begin
                    mon_b = exp_tx.pop_front();
                    check("tx_data", 32'(bif.tx_data), 32'(mon_b));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        bif.rx_valid = 1'b1;
        bif.rx_data  = b;
        @(posedge clk);
        #1;
        bif.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 5000) begin
            @(negedge clk);
            if (!bif.busy) break;
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
        end
    endtask

    task automatic set_addr(input logic [31:0] a);
        exp_tx.push_back(8'h06);
        send(8'h01);
        for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
        wait_idle("set_addr");
    endtask

    task automatic push_acc(input logic wr, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        acc_t e;
        e.wr = wr; e.addr = a; e.mask = m; e.data = d;
        exp_mem.push_back(e);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  m;
        logic [7:0]  b;
        int          n;
        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'h00;
        bif.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(bif.tx_valid), 0);
        check("rst_mem_valid", 32'(bif.mem_valid), 0);
        check("rst_mem_write", 32'(bif.mem_write), 0);
        check("rst_busy", 32'(bif.busy), 0);
        check("rst_mem_wmask", 32'(bif.mem_wmask), 0);
        check("rst_mem_wdata", bif.mem_wdata, 0);
        check("rst_mem_addr", bif.mem_addr, 0);
        check("rst_tx_data", 32'(bif.tx_data), 0);
        rst = 1'b0;

        exp_tx.push_back(8'h06);
        send(8'h01); send(8'h00); send(8'h00); send(8'h02); send(8'h00);
        check("ack_rise", 32'(bif.tx_valid), 1);
        check("ack_busy", 32'(bif.busy), 1);
        wait_idle("addr1");
        push_acc(1'b1, 32'h0002_0000, 4'b0001, 32'hAAAA_AAAA);
        push_acc(1'b1, 32'h0002_0000, 4'b0010, 32'hBBBB_BBBB);
        push_acc(1'b1, 32'h0002_0000, 4'b0100, 32'hCCCC_CCCC);
        exp_tx.push_back(8'h06);
        send(8'h02); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
        wait_idle("write3");

        mem[32'h0002_0000] = 32'hDDCC_BBAA;
        set_addr(32'h0002_0001);
        bif.tx_ready = 1'b0;
        push_acc(1'b0, 32'h0002_0000, 4'b0000, 32'h0);
        push_acc(1'b0, 32'h0002_0000, 4'b0000, 32'h0);
        exp_tx.push_back(8'hBB);
        exp_tx.push_back(8'hCC);
        send(8'h03); send(8'h02);
        n = 0;
        while (n < 50 && !bif.tx_valid) begin
            @(negedge clk);
            n++;
        end
        check("read_tx_rise", 32'(bif.tx_valid), 1);
        repeat (5) begin
            @(negedge clk);
            check("stall_tx_valid", 32'(bif.tx_valid), 1);
            check("stall_tx_data", 32'(bif.tx_data), 32'h0000_00BB);
        end
        @(posedge clk);
        #1;
        bif.tx_ready = 1'b1;
        wait_idle("read2");

        set_addr(32'h0000_0003);
        push_acc(1'b1, 32'h0000_0000, 4'b1000, 32'h1111_1111);
        push_acc(1'b1, 32'h0000_0004, 4'b0001, 32'h2222_2222);
        exp_tx.push_back(8'h06);
        send(8'h02); send(8'h02); send(8'h11); send(8'h22);
        wait_idle("cross");

        set_addr(32'hFFFF_FF00);
        for (int i = 0; i < 256; i++) begin
            a = 32'hFFFF_FF00 + 32'(i);
            m = 4'b0001 << a[1:0];
            b = 8'(i);
            push_acc(1'b1, {a[31:2], 2'b00}, m, {4{b}});
        end
        exp_tx.push_back(8'h06);
        send(8'h02); send(8'h00);
        for (int i = 0; i < 256; i++) send(8'(i));
        wait_idle("wrap_write");
        mem[32'h0] = 32'h1234_5678;
        push_acc(1'b0, 32'h0000_0000, 4'b0000, 32'h0);
        exp_tx.push_back(8'h78);
        send(8'h03); send(8'h01);
        wait_idle("wrap_read");

        exp_tx.push_back(8'h3F);
        send(8'h7E);
        check("nak_rise", 32'(bif.tx_valid), 1);
        check("nak_busy", 32'(bif.busy), 1);
        wait_idle("nak");
        check("nak_busy_low", 32'(bif.busy), 0);

        set_addr(32'h0000_0100);
        push_acc(1'b1, 32'h0000_0100, 4'b0001, 32'hAAAA_AAAA);
        send(8'h02); send(8'h03); send(8'hAA);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_mem_valid", 32'(bif.mem_valid), 0);
        check("arst_mem_write", 32'(bif.mem_write), 0);
        check("arst_mem_wmask", 32'(bif.mem_wmask), 0);
        check("arst_busy", 32'(bif.busy), 0);
        check("arst_tx_valid", 32'(bif.tx_valid), 0);
        check("arst_mem_addr", bif.mem_addr, 0);
        check("arst_mem_wdata", bif.mem_wdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_addr(32'h0000_0040);
        check("mem_drained", exp_mem.size(), 0);
        check("tx_drained", exp_tx.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
